// File: rtl/guess_scorer_pkg.sv
// ============================================================================
// guess_scorer_pkg : shared letter/colour codes, FSM states, slot helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package guess_scorer_pkg;

  localparam int          c_slot_w         = 7;
  localparam int          c_letter_w       = 5;
  localparam int          c_slots          = 5;
  localparam logic [4:0]  c_letter_empty   = 5'd26;

  localparam logic [1:0]  c_color_unscored = 2'b00;
  localparam logic [1:0]  c_color_absent   = 2'b01;
  localparam logic [1:0]  c_color_present  = 2'b10;
  localparam logic [1:0]  c_color_correct  = 2'b11;

  localparam logic [34:0] c_empty_row      = {5{c_color_unscored, c_letter_empty}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [4:0] get_letter(input logic [24:0] word, input logic [2:0] idx);
    return word[idx*c_letter_w +: c_letter_w];
  endfunction

endpackage

`default_nettype wire

// File: rtl/guess_scorer_if.sv
// ============================================================================
// guess_scorer_if : row-submit request/response bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface guess_scorer_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             new_game;
  logic [24:0]      guess;
  logic [24:0]      target;
  logic             busy;
  logic             done;
  logic [34:0]      row_out;
  logic             win;
  logic             game_over;
  logic [CNT_W-1:0] guess_count;

  modport master (
    output start, new_game, guess, target,
    input  busy, done, row_out, win, game_over, guess_count
  );

  modport slave (
    input  start, new_game, guess, target,
    output busy, done, row_out, win, game_over, guess_count
  );
endinterface

`default_nettype wire

// File: rtl/guess_scorer_letter_match_finder.sv
// ============================================================================
// letter_match_finder : lowest unused target slot holding a given letter
// Revision: 1.0
// ============================================================================
`default_nettype none

module letter_match_finder
  import guess_scorer_pkg::*;
(
  input  logic [4:0]  letter,
  input  logic [24:0] target,
  input  logic [4:0]  used,
  output logic        found,
  output logic [2:0]  pos
);

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    found = 1'b0;
    pos   = 3'd0;
    for (int j = c_slots - 1; j >= 0; j--) begin
      if (!used[j] && (target[j*c_letter_w +: c_letter_w] == letter) &&
          (letter < c_letter_empty)) begin
        found = 1'b1;
        pos   = 3'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/guess_scorer.sv
// ============================================================================
// guess_scorer : sequential Wordle row scorer with guess/win/game-over tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int MAX_GUESSES = 6,
  parameter int CNT_W       = 3
) (
  input  logic           logicclk,
  input  logic           clr,
  guess_scorer_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_max_guesses = CNT_W'(MAX_GUESSES);

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_idx;
  logic [24:0]        r_guess;
  logic [24:0]        r_target;
  logic [4:0]         r_green;
  logic [4:0]         r_used;
  logic [4:0][1:0]    r_colors;
  logic [34:0]        r_row;
  logic               r_done;
  logic               r_win;
  logic               r_game_over;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic               w_idx_last;
  logic [4:0]         w_g_letter;
  logic [4:0]         w_t_letter;
  logic               w_found;
  logic [2:0]         w_pos;
  logic [34:0]        w_row;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_win;

  assign w_g_letter   = get_letter(r_guess, r_idx);
  assign w_t_letter   = get_letter(r_target, r_idx);
  assign w_idx_last   = (r_idx == 3'd4);
  assign w_accept     = bus.start && !r_game_over;
  assign w_win        = &r_green;
  assign w_count_next = (r_count == c_max_guesses) ? r_count : r_count + 1'b1;

  letter_match_finder u_finder (
    .letter (w_g_letter),
    .target (r_target),
    .used   (r_used),
    .found  (w_found),
    .pos    (w_pos)
  );

  for (genvar i = 0; i < c_slots; i++) begin : g_row
    assign w_row[i*c_slot_w +: c_slot_w] = {r_colors[i], r_guess[i*c_letter_w +: c_letter_w]};
  end

  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_state_next = ST_GREEN;
      ST_GREEN:  if (w_idx_last) w_state_next = ST_YELLOW;
      ST_YELLOW: if (w_idx_last) w_state_next = ST_DONE;
      ST_DONE:                   w_state_next = ST_IDLE;
      default:                   w_state_next = ST_IDLE;
    endcase
    if (bus.new_game) w_state_next = ST_IDLE;
  end

  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) begin
      r_idx       <= 3'd0;
      r_guess     <= '0;
      r_target    <= '0;
      r_green     <= '0;
      r_used      <= '0;
      r_colors    <= '0;
      r_row       <= c_empty_row;
      r_done      <= 1'b0;
      r_win       <= 1'b0;
      r_game_over <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.new_game) begin
        r_idx       <= 3'd0;
        r_row       <= c_empty_row;
        r_win       <= 1'b0;
        r_game_over <= 1'b0;
        r_count     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_guess  <= bus.guess;
              r_target <= bus.target;
              r_green  <= '0;
              r_used   <= '0;
              r_colors <= '0;
              r_idx    <= 3'd0;
            end
          end
          ST_GREEN: begin
            if ((w_g_letter == w_t_letter) && (w_g_letter < c_letter_empty)) begin
              r_green[r_idx] <= 1'b1;
              r_used[r_idx]  <= 1'b1;
            end
            r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
          end
          ST_YELLOW: begin
            if (r_green[r_idx]) begin
              r_colors[r_idx] <= c_color_correct;
            end else if (w_found) begin
              r_used[w_pos]   <= 1'b1;
              r_colors[r_idx] <= c_color_present;
            end else begin
              r_colors[r_idx] <= c_color_absent;
            end
            r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
          end
          ST_DONE: begin
            r_row       <= w_row;
            r_done      <= 1'b1;
            r_win       <= w_win;
            r_count     <= w_count_next;
            r_game_over <= w_win || (w_count_next == c_max_guesses);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.row_out     = r_row;
  assign bus.win         = r_win;
  assign bus.game_over   = r_game_over;
  assign bus.guess_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_guess_scorer.sv
// Directed + randomized bench for guess_scorer; reference scores rows by letter counting.
`default_nettype none

module tb_guess_scorer;

  localparam logic [34:0] EMPTY_ROW = 35'b00110100011010001101000110100011010;

  logic logicclk = 1'b0;
  logic clr      = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  int   m_count  = 0;
  logic m_win    = 1'b0;
  logic m_over   = 1'b0;

  guess_scorer_if #(.CNT_W(3)) bus ();

  guess_scorer #(.MAX_GUESSES(6), .CNT_W(3)) dut (
    .logicclk (logicclk),
    .clr      (clr),
    .bus      (bus)
  );

  always #5 logicclk = ~logicclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge logicclk);
    #1;
  endtask

  function automatic logic [24:0] word(input int a, input int b, input int c, input int d, input int e);
    logic [4:0] s0, s1, s2, s3, s4;
    s0 = a[4:0]; s1 = b[4:0]; s2 = c[4:0]; s3 = d[4:0]; s4 = e[4:0];
    return {s4, s3, s2, s1, s0};
  endfunction

  // Wordle scoring by counting leftover target letters after greens are removed.
  function automatic logic [34:0] ref_score(input logic [24:0] g, input logic [24:0] t);
    int         cnt [32];
    logic [4:0] gl [5];
    logic [4:0] tl [5];
    logic [1:0] col;
    logic [34:0] row;
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    for (int i = 0; i < 5; i++) begin
      gl[i] = g[5*i +: 5];
      tl[i] = t[5*i +: 5];
    end
    for (int i = 0; i < 5; i++)
      if (!(gl[i] == tl[i] && gl[i] < 26) && tl[i] < 26) cnt[tl[i]]++;
    for (int i = 0; i < 5; i++) begin
      if (gl[i] == tl[i] && gl[i] < 26) col = 2'b11;
      else if (gl[i] < 26 && cnt[gl[i]] > 0) begin
        col = 2'b10;
        cnt[gl[i]]--;
      end else col = 2'b01;
      row[7*i +: 7] = {col, gl[i]};
    end
    return row;
  endfunction

  function automatic logic all_green(input logic [34:0] row);
    for (int i = 0; i < 5; i++) if (row[7*i+5 +: 2] != 2'b11) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_commit(input logic [24:0] g, input logic [24:0] t, output logic [34:0] row);
    row    = ref_score(g, t);
    m_win  = all_green(row);
    if (m_count < 6) m_count++;
    m_over = m_win || (m_count == 6);
  endtask

  task automatic model_clear();
    m_count = 0; m_win = 1'b0; m_over = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_win"},   64'(bus.win),         64'(m_win));
    check({tag, "_over"},  64'(bus.game_over),   64'(m_over));
    check({tag, "_count"}, 64'(bus.guess_count), 64'(m_count));
  endtask

  task automatic run_row(input string tag, input logic [24:0] g, input logic [24:0] t);
    int          n;
    logic        got;
    logic [34:0] exp_row;
    bus.guess = g; bus.target = t; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.guess = '1; bus.target = '1;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 0; got = 1'b0;
    while (n < 30 && !got) begin
      step();
      n++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_done_timeout"}, 64'(got), 64'd1);
    end else begin
      model_commit(g, t, exp_row);
      check({tag, "_latency"}, 64'(n), 64'd11);
      check({tag, "_row"}, 64'(bus.row_out), 64'(exp_row));
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check_status(tag);
      step();
      check({tag, "_done_single"}, 64'(bus.done), 64'd0);
      check({tag, "_row_hold"}, 64'(bus.row_out), 64'(exp_row));
    end
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    model_clear();
  endtask

  function automatic logic [24:0] rand_word();
    logic [24:0] w;
    for (int i = 0; i < 5; i++)
      w[5*i +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31))
                                                 : 5'($urandom_range(0, 4));
    return w;
  endfunction

  initial begin
    logic [24:0] g, t;
    int          dones;
    bus.start = 1'b0; bus.new_game = 1'b0; bus.guess = '0; bus.target = '0;
    step(); step();
    clr = 1'b0;
    step();

    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_row",  64'(bus.row_out), 64'(EMPTY_ROW));
    check_status("rst");

    // T1: exact match ends the game on the first row
    run_row("t1", word(0, 1, 2, 3, 4), word(0, 1, 2, 3, 4));
    check("t1_row_const", 64'(bus.row_out), 64'({7'h60|7'd4, 7'h60|7'd3, 7'h60|7'd2, 7'h60|7'd1, 7'h60|7'd0}));
    bus.start = 1'b1; bus.guess = word(1, 1, 1, 1, 1); bus.target = word(2, 2, 2, 2, 2);
    step();
    bus.start = 1'b0;
    check("t1_start_after_over", 64'(bus.busy), 64'd0);
    pulse_new_game();
    check("ng_row", 64'(bus.row_out), 64'(EMPTY_ROW));
    check_status("ng");

    // T2: duplicate accounting
    run_row("t2", word(1, 1, 1, 0, 0), word(0, 1, 1, 4, 24));
    check("t2_row_const", 64'(bus.row_out),
          64'({2'b01, 5'd0, 2'b10, 5'd0, 2'b11, 5'd1, 2'b11, 5'd1, 2'b01, 5'd1}));

    // T3: empty letters never match
    run_row("t3", word(26, 26, 26, 26, 26), word(0, 1, 2, 3, 4));
    check("t3_row_const", 64'(bus.row_out), 64'({5{2'b01, 5'd26}}));

    // T4: six random non-winning rows reach the guess limit
    pulse_new_game();
    for (int r = 0; r < 6; r++) begin
      g = rand_word(); t = rand_word();
      g[4:0] = 5'd31;
      run_row("t4", g, t);
    end
    dones = 0;
    bus.start = 1'b1; bus.guess = word(0, 0, 0, 0, 0); bus.target = word(0, 0, 0, 0, 0);
    step();
    bus.start = 1'b0;
    check("t4_7th_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 15; k++) begin step(); if (bus.done) dones++; end
    check("t4_7th_done", 64'(dones), 64'd0);

    // Randomized games against the reference
    pulse_new_game();
    for (int r = 0; r < 20; r++) begin
      if (m_over) pulse_new_game();
      g = rand_word();
      t = ($urandom_range(0, 4) == 0) ? g : rand_word();
      run_row("rnd", g, t);
    end

    // T5: start while busy is dropped; clr aborts scoring
    pulse_new_game();
    g = word(0, 2, 2, 3, 7); t = word(2, 0, 2, 5, 7);
    bus.guess = g; bus.target = t; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin step(); if (bus.done) dones++; end
    check("t5_one_done", 64'(dones), 64'd1);
    begin
      logic [34:0] tmp;
      model_commit(g, t, tmp);
      check("t5_row", 64'(bus.row_out), 64'(tmp));
    end
    check_status("t5");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    clr = 1'b1;
    #1;
    model_clear();
    check("t5_clr_busy", 64'(bus.busy), 64'd0);
    check("t5_clr_row",  64'(bus.row_out), 64'(EMPTY_ROW));
    check_status("t5_clr");
    step();
    clr = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin step(); if (bus.done) dones++; end
    check("t5_clr_no_done", 64'(dones), 64'd0);

    // T6: new_game aborts mid-YELLOW; new_game beats start
    run_row("t6_pre", word(3, 3, 3, 3, 3), word(3, 1, 1, 1, 1));
    bus.start = 1'b1; bus.guess = word(1, 2, 3, 4, 5); bus.target = word(5, 4, 3, 2, 1);
    step();
    bus.start = 1'b0;
    repeat (7) step();
    check("t6_busy_yellow", 64'(bus.busy), 64'd1);
    pulse_new_game();
    check("t6_ng_busy", 64'(bus.busy), 64'd0);
    check("t6_ng_row", 64'(bus.row_out), 64'(EMPTY_ROW));
    check_status("t6_ng");
    dones = 0;
    for (int k = 0; k < 15; k++) begin step(); if (bus.done) dones++; end
    check("t6_no_done", 64'(dones), 64'd0);
    bus.start = 1'b1; bus.new_game = 1'b1;
    step();
    bus.start = 1'b0; bus.new_game = 1'b0;
    check("t6_both_busy", 64'(bus.busy), 64'd0);
    step();
    check("t6_both_busy2", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
